// File: rtl/borrow_decrement_subtractor.sv
// Two-stage pipelined unsigned subtractor: split-half subtract, then a
// borrow-decrement chain corrects the upper half with the lower-half borrow.
module borrow_decrement_subtractor #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   diff
);

  localparam int H = N / 2;

  logic         s1_v;
  logic [H-1:0] lo_d;
  logic         lo_b;
  logic [H-1:0] hi_d;
  logic         hi_b;
  logic         s2_v;

  logic         accept;
  logic         s2_load;
  logic [H:0]   lo_sub;
  logic [H:0]   hi_sub;
  logic [H-1:0] hi_f;
  logic [H:0]   chain_b;

  assign in_ready  = !s1_v || !s2_v || out_ready;
  assign accept    = in_valid && in_ready;
  assign s2_load   = s1_v && (!s2_v || out_ready);
  assign out_valid = s2_v;

  // Both halves subtract with borrow-in 0; the extra MSB is the borrow-out.
  assign lo_sub = {1'b0, in1[H-1:0]} - {1'b0, in2[H-1:0]};
  assign hi_sub = {1'b0, in1[N-1:H]} - {1'b0, in2[N-1:H]};

  // Half-subtractor per bit; the chain borrow only survives through zero bits.
  always_comb begin
    chain_b    = '0;
    hi_f       = '0;
    chain_b[0] = lo_b;
    for (int i = 0; i < H; i++) begin
      hi_f[i]      = hi_d[i] ^ chain_b[i];
      chain_b[i+1] = ~hi_d[i] & chain_b[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      lo_d <= '0;
      lo_b <= 1'b0;
      hi_d <= '0;
      hi_b <= 1'b0;
      s2_v <= 1'b0;
      diff <= '0;
    end else begin
      if (accept) begin
        s1_v <= 1'b1;
        lo_d <= lo_sub[H-1:0];
        lo_b <= lo_sub[H];
        hi_d <= hi_sub[H-1:0];
        hi_b <= hi_sub[H];
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end

      if (s2_load) begin
        s2_v <= 1'b1;
        diff <= {hi_b | chain_b[H], hi_f, lo_d};
      end else if (out_ready) begin
        s2_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_borrow_decrement_subtractor.sv
// Bench for borrow_decrement_subtractor: directed borrow/flow-control cases,
// then throttled random traffic against a plain-arithmetic scoreboard.
module tb_borrow_decrement_subtractor;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in1;
  logic [N-1:0] in2;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   diff;

  int checks   = 0;
  int failures = 0;

  logic [N:0] exp_q[$];
  logic       mon_en = 1'b0;
  logic       prev_stall = 1'b0;
  logic [N:0] prev_diff;
  int         acc_cnt = 0;

  borrow_decrement_subtractor #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, expv);
    end
  endtask

  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Single op with out_ready held high: diff must appear exactly 2 edges after accept.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
    in1 = a;
    in2 = b;
    in_valid = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, 64'(out_valid), 64'd0);
    next_cycle();
    @(negedge clk);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_diff"}, 64'(diff), 64'(model(a, b)));
    next_cycle();
  endtask

  // Scoreboard monitor, sampled on the falling edge while inputs are stable.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_diff", 64'(diff), 64'(prev_diff));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 64'd1, 64'd0);
        else chk("rand_diff", 64'(diff), 64'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in1, in2));
        acc_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_diff  = diff;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    logic [N:0] want[3];
    int         got;
    int         cyc;
    logic       c_taken;
    logic [N-1:0] a;
    logic [N-1:0] b;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in1 = '0;
    in2 = '0;
    repeat (2) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_diff", 64'(diff), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    next_cycle();

    run_op("t1", 32'h0000_0005, 32'h0000_0003);
    run_op("t2", 32'h0001_0000, 32'h0000_0001);
    run_op("t3", 32'h0000_0000, 32'h0000_0001);
    run_op("eq", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_op("hi0", 32'h1234_0000, 32'h1234_0001);

    // Backpressure: three back-to-back pushes with the consumer stalled.
    want[0] = 33'h0_0000_0005;
    want[1] = 33'h1_FFFF_FFFB;
    want[2] = 33'h0_0000_0000;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in1 = 32'd9; in2 = 32'd4;
    next_cycle();
    in1 = 32'd4; in2 = 32'd9;
    next_cycle();
    in1 = 32'h8000_0000; in2 = 32'h8000_0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_valid", 64'(out_valid), 64'd1);
      chk("full_diff", 64'(diff), 64'(want[0]));
      next_cycle();
    end
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      c_taken = in_valid && in_ready;
      if (out_valid) begin
        if (got < 3) chk("drain_diff", 64'(diff), 64'(want[got]));
        else chk("drain_extra", 64'd1, 64'd0);
        got++;
      end
      next_cycle();
      if (c_taken) in_valid = 1'b0;
    end
    chk("drain_count", 64'(got), 64'd3);

    // Reset while an op is still in stage 1.
    in1 = 32'd100; in2 = 32'd1;
    in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_diff", 64'(diff), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      chk("midrst_no_out", 64'(out_valid), 64'd0);
    end
    next_cycle();

    // Random throttled traffic.
    mon_en = 1'b1;
    cyc = 0;
    while (acc_cnt < 10000 && cyc < 60000) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = a;
        1: a[N-1:N/2] = b[N-1:N/2];
        2: a = '0;
        3: b = '1;
        default: ;
      endcase
      in1 = a;
      in2 = b;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      next_cycle();
      cyc++;
    end
    chk("rand_accept_count", 64'(acc_cnt >= 10000), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) next_cycle();
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
